priority_encoder_16_4: RTL

// - Inverse of the team's 4->16 decoder: collects 16 request lines and returns the
//   4-bit index of one pending request per handshake.
// - Requests are latched as sticky pending bits. Output is registered with a valid/ready handshake.
// - Sits between the interrupt/request sources and the controller that services them.

---
 rtl/priority_encoder_16_4_pkg.sv | 15 +
 rtl/priority_encoder_16_4_if.sv | 25 ++
 rtl/priority_encoder_16_4_pick.sv | 19 +
 rtl/priority_encoder_16_4.sv | 95 +++++++++
 4 files changed

// File: rtl/priority_encoder_16_4_pkg.sv
// Shared constants and types for the 16-request priority encoder.
package prio_enc_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/priority_encoder_16_4_if.sv
// Request/grant bundle between the request sources, the encoder and its consumer.
interface priority_encoder_16_4_if;
  import prio_enc_pkg::*;

  logic     enable;
  req_vec_t req;
  idx_t     out;
  logic     out_valid;
  logic     out_ready;
  req_vec_t pending;
  logic     none;

  // Encoder side.
  modport slave (
    input  enable, req, out_ready,
    output out, out_valid, pending, none
  );

  // Source/consumer side.
  modport master (
    output enable, req, out_ready,
    input  out, out_valid, pending, none
  );

endinterface

// File: rtl/priority_encoder_16_4_pick.sv
// Combinational lowest-set-bit finder over a 16-bit vector.
module prio_pick
  import prio_enc_pkg::*;
(
  input  req_vec_t vec,
  output idx_t     idx,
  output logic     found
);

  always_comb begin
    idx   = '0;
    found = |vec;
    // Walk from the top so the lowest set bit is the last one written.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (vec[i]) idx = idx_t'(i);
    end
  end

endmodule

// File: rtl/priority_encoder_16_4.sv
// Sticky-pending 16->4 priority encoder with a registered valid/ready grant.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module priority_encoder_16_4
  import prio_enc_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  priority_encoder_16_4_if.slave bus
);

  req_vec_t r_pending;
  idx_t     r_out;
  state_t   r_state;

  logic     w_hold;
  logic     w_accept;
  req_vec_t w_out_onehot;
  req_vec_t w_cand;
  req_vec_t w_clear;
  req_vec_t w_pending_next;
  req_vec_t w_search;
  idx_t     w_pick_idx;
  logic     w_found;
  idx_t     w_grant;

  assign w_hold       = (r_state == HOLD);
  assign w_accept     = w_hold & bus.out_ready;
  assign w_out_onehot = req_vec_t'(1) << r_out;

  // The held grant is never a candidate for the next one.
  assign w_cand         = w_hold ? (r_pending & ~w_out_onehot) : r_pending;
  assign w_clear        = w_accept ? w_out_onehot : '0;
  assign w_pending_next = (r_pending & ~w_clear) | bus.req;

`ifdef ROUND_ROBIN_EN
  idx_t r_rr;
  idx_t w_start;

  // On a back-to-back accept the pointer has not moved yet, so derive it from out.
  assign w_start  = w_accept ? (r_out + idx_t'(1)) : r_rr;
  assign w_search = req_vec_t'({w_cand, w_cand} >> w_start);
  assign w_grant  = w_pick_idx + w_start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr <= '0;
    end else if (w_accept) begin
      r_rr <= r_out + idx_t'(1);
    end
  end
`else
  assign w_search = w_cand;
  assign w_grant  = w_pick_idx;
`endif

  prio_pick u_pick (
    .vec   (w_search),
    .idx   (w_pick_idx),
    .found (w_found)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= '0;
      r_out     <= '0;
      r_state   <= IDLE;
    end else begin
      r_pending <= w_pending_next;
      case (r_state)
        IDLE: begin
          if (bus.enable && w_found) begin
            r_out   <= w_grant;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            if (bus.enable && w_found) begin
              r_out <= w_grant;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.out       = r_out;
  assign bus.out_valid = w_hold;
  assign bus.pending   = r_pending;
  assign bus.none      = (r_pending == '0) && !w_hold;

endmodule
